// File: rtl/elevator_req_latch.sv
// Request front end for ELEVATOR: synchronizes the seven call buttons and latches
// rising edges as pending calls. Calls clear on service; a long car-button press raises Hold_Open.
module elevator_req_latch #(
    parameter int HOLD_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       U1,
    input  logic       U2,
    input  logic       D2,
    input  logic       D3,
    input  logic       Open,
    input  logic [1:0] Floor,
    input  logic [1:0] Direction,
    output logic [2:0] Req_Car,
    output logic [1:0] Req_Up,
    output logic [1:0] Req_Dn,
    output logic       Any_Req,
    output logic       New_Req,
    output logic       Hold_Open
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC);
    localparam logic [1:0] DIR_UP = 2'd1;
    localparam logic [1:0] DIR_DN = 2'd2;

    // Bit layout shared by the sync chain and the pending vector:
    // [2:0] car F3..F1, [4:3] up U2,U1, [6:5] down D3,D2.
    logic [6:0] raw, s1, s2, s3, rise;
    logic [6:0] pend, clr, pend_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0] prev_floor;
    logic       car_btn, hold_run;

    assign raw  = {D3, D2, U2, U1, F3, F2, F1};
    assign rise = s2 & ~s3;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        clr = '0;
        if (Open) begin
            unique case (Floor)
                2'd1: begin
                    clr[0] = 1'b1;
                    clr[3] = 1'b1;
                end
                2'd2: begin
                    clr[1] = 1'b1;
                    clr[4] = (Direction != DIR_DN);
                    clr[5] = (Direction != DIR_UP);
                end
                2'd3: begin
                    clr[2] = 1'b1;
                    clr[6] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a same-cycle rise on the same bit.
    assign pend_nxt = (pend | rise) & ~clr;

    always_comb begin
        car_btn = 1'b0;
        unique case (Floor)
            2'd1:    car_btn = s2[0];
            2'd2:    car_btn = s2[1];
            2'd3:    car_btn = s2[2];
            default: car_btn = 1'b0;
        endcase
    end

    assign hold_run = Open && car_btn && (Floor == prev_floor);

    always_comb begin
        hold_cnt_nxt = '0;
        if (hold_run)
            hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pend       <= '0;
            hold_cnt   <= '0;
            prev_floor <= '0;
            New_Req    <= 1'b0;
            Hold_Open  <= 1'b0;
        end else begin
            s1         <= raw;
            s2         <= s1;
            s3         <= s2;
            pend       <= pend_nxt;
            hold_cnt   <= hold_cnt_nxt;
            prev_floor <= Floor;
            New_Req    <= |(pend_nxt & ~pend);
            Hold_Open  <= (hold_cnt_nxt == HOLD_MAX);
        end
    end

    assign Req_Car = pend[2:0];
    assign Req_Up  = pend[4:3];
    assign Req_Dn  = pend[6:5];
    assign Any_Req = |pend;

endmodule
